pool_flatten: RTL and testbench

- Streaming 2x2 max-pool and flatten stage that produces the pooled feature vector consumed by the fully-connected layer.
- Accepts one conv-output pixel per cycle in raster order.
- Pools non-overlapping 2x2 windows and packs the results row-major into a vector.
- Emits a one-cycle vec_valid pulse when the frame is complete; this pulse drives the FC layer's valid_in directly.

---
 rtl/cnn_pkg.sv | 12 +
 rtl/pool_flatten.sv | 92 +++++++++
 tb/tb_pool_flatten.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers used by the pooling stages.
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] pixel_t;

  function automatic pixel_t max2(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_flatten.sv
// Streaming 2x2 max-pool + flatten into the FC input vector.
// Define POOL_RELU_EN to clamp each accepted pixel at zero before pooling.
module pool_flatten
  import cnn_pkg::*;
#(
  parameter  int IMG_W  = 4,
  parameter  int IMG_H  = 4,
  parameter  int DATA_W = cnn_pkg::DATA_W,
  localparam int OUT_N  = (IMG_W / 2) * (IMG_H / 2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  output logic signed [DATA_W-1:0] vec_out [0:OUT_N-1],
  output logic                     vec_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LN = IMG_W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;
  localparam int IW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pixel_t        pair_hold;
  pixel_t        line_buf [0:LN-1];
  pixel_t        shadow   [0:OUT_N-1];

  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_col;
  logic          last_row;
  logic [LW-1:0] lb_idx;
  logic [IW-1:0] sh_idx;
  pixel_t        px;
  pixel_t        elem;

  // sof overrides the counters so the accepted pixel is always treated as (0,0)
  always_comb begin
    cur_col  = pix_sof ? '0 : col;
    cur_row  = pix_sof ? '0 : row;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    lb_idx   = LW'(cur_col >> 1);
    sh_idx   = IW'(int'(cur_row >> 1) * LN + int'(cur_col >> 1));
`ifdef POOL_RELU_EN
    px       = pix_in[DATA_W-1] ? '0 : pix_in;
`else
    px       = pix_in;
`endif
    elem     = max2(max2(line_buf[lb_idx], pair_hold), px);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      pair_hold <= '0;
      line_buf  <= '{default: '0};
      shadow    <= '{default: '0};
      vec_out   <= '{default: '0};
      vec_valid <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      if (pix_valid) begin
        col <= last_col ? '0 : cur_col + 1'b1;
        if (last_col)
          row <= last_row ? '0 : cur_row + 1'b1;
        else
          row <= cur_row;

        if (!cur_col[0]) begin
          pair_hold <= px;
        end else if (!cur_row[0]) begin
          line_buf[lb_idx] <= max2(pair_hold, px);
        end else begin
          shadow[sh_idx] <= elem;
          // final element bypasses shadow so the published vector is complete
          if (last_row && last_col) begin
            for (int unsigned i = 0; i < OUT_N; i++)
              vec_out[i] <= (IW'(i) == sh_idx) ? elem : shadow[i];
            vec_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_flatten.sv
// Self-checking bench for pool_flatten against a frame-level reference model.
module tb_pool_flatten;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int N  = (W / 2) * (H / 2);
  localparam int NP = W * H;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] pix_in;
  logic                 pix_valid;
  logic                 pix_sof;
  logic signed [DW-1:0] vec_out [0:N-1];
  logic                 vec_valid;

  pool_flatten #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .vec_out   (vec_out),
    .vec_valid (vec_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned pulses = 0;

  // reference model: collected frame image and published vector
  int img [0:NP-1];
  int exp_vec [0:N-1];
  int pos;
  bit exp_pulse;

  task automatic check(input string tag, input longint got, input longint expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int sx(input int v);
    logic signed [DW-1:0] t;
    t = DW'(v);
    return int'(t);
  endfunction

  task automatic model_reset();
    pos = 0;
    exp_pulse = 1'b0;
    for (int i = 0; i < N; i++) exp_vec[i] = 0;
  endtask

  task automatic publish();
    for (int pr = 0; pr < H / 2; pr++)
      for (int pc = 0; pc < W / 2; pc++) begin
        int m;
        m = img[(2 * pr) * W + 2 * pc];
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            if (img[(2 * pr + dy) * W + 2 * pc + dx] > m)
              m = img[(2 * pr + dy) * W + 2 * pc + dx];
        exp_vec[pr * (W / 2) + pc] = m;
      end
  endtask

  task automatic compare_outputs();
    check("vec_valid", longint'(vec_valid), longint'(exp_pulse));
    for (int i = 0; i < N; i++)
      check($sformatf("vec_out[%0d]", i), longint'(vec_out[i]), longint'(exp_vec[i]));
    if (vec_valid) pulses++;
  endtask

  // one clock: drive at negedge, model update at posedge, check at next negedge
  task automatic step(input bit v, input bit sof, input int pix);
    pix_valid = v;
    pix_sof   = sof;
    pix_in    = DW'(pix);
    @(posedge clk);
    exp_pulse = 1'b0;
    if (v) begin
      if (sof) pos = 0;
      img[pos] = relu(sx(pix));
      if (pos == NP - 1) begin
        publish();
        exp_pulse = 1'b1;
        pos = 0;
      end else begin
        pos++;
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_in = '0;
    #1;
    model_reset();
    @(negedge clk);
    compare_outputs();
    reset = 1'b0;
  endtask

  task automatic expect_vec(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_0"}, longint'(vec_out[0]), longint'(e0));
    check({tag, "_1"}, longint'(vec_out[1]), longint'(e1));
    check({tag, "_2"}, longint'(vec_out[2]), longint'(e2));
    check({tag, "_3"}, longint'(vec_out[3]), longint'(e3));
  endtask

  initial begin
    reset = 1'b0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_in = '0;
    @(negedge clk);
    do_reset();
    expect_vec("reset_vec", 0, 0, 0, 0);

    // ramp frame, continuous valid
    pulses = 0;
    for (int i = 0; i < NP; i++) step(1'b1, i == 0, i);
    step(1'b0, 1'b0, 0);
    check("ramp_pulses", pulses, 1);
    expect_vec("ramp", 5, 7, 13, 15);

    // negative ramp
    for (int i = 0; i < NP; i++) step(1'b1, 1'b0, -i);
`ifdef POOL_RELU_EN
    expect_vec("neg", 0, 0, 0, 0);
`else
    expect_vec("neg", 0, -2, -8, -10);
`endif

    // gapped valid
    pulses = 0;
    for (int i = 0; i < NP; i++) begin
      step(1'b1, 1'b0, i);
      step(1'b0, 1'b0, 12345);
    end
    check("gap_pulses", pulses, 1);
    expect_vec("gap", 5, 7, 13, 15);

    // partial frame abandoned by sof
    pulses = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 50 + i);
    step(1'b0, 1'b1, 999);
    for (int i = 0; i < NP; i++) step(1'b1, i == 0, i);
    step(1'b0, 1'b0, 0);
    check("sof_pulses", pulses, 1);
    expect_vec("sof", 5, 7, 13, 15);

    // back-to-back frames
    pulses = 0;
    for (int i = 0; i < NP; i++) step(1'b1, 1'b0, i);
    for (int i = 0; i < NP - 1; i++) step(1'b1, 1'b0, 100);
    expect_vec("b2b_hold", 5, 7, 13, 15);
    step(1'b1, 1'b0, 100);
    step(1'b0, 1'b0, 0);
    check("b2b_pulses", pulses, 2);
    expect_vec("b2b", 100, 100, 100, 100);

    // reset mid-frame
    pulses = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 77);
    do_reset();
    expect_vec("midrst", 0, 0, 0, 0);
    for (int i = 0; i < NP; i++) step(1'b1, 1'b0, i);
    check("midrst_pulses", pulses, 1);
    expect_vec("midrst_after", 5, 7, 13, 15);

    // randomized frames with gaps, extremes and occasional sof restarts
    for (int k = 0; k < 400; k++) begin
      int r;
      int pv;
      r = int'($urandom_range(0, 9));
      case (r)
        0: pv = -32768;
        1: pv = 32767;
        default: pv = int'($urandom_range(0, 65535)) - 32768;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, pv);
    end
    step(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
